uart_tx_sched: RTL
==================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter CLK_DIV, default 3125, clk30M cycles per UART bit (30 MHz / 9600 baud); legal range 2..4095.
REQ-002 Parameter DATA_W, default 8, data bits per frame.
REQ-003 clk30M  in  1  system clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req0_valid  in  1  requester 0 has a byte to send.
REQ-006 req0_data  in  DATA_W  requester 0 payload.
REQ-007 req0_ready  out  1  requester 0 byte accepted this cycle when req0_valid is also high.
REQ-008 req1_valid  in  1  requester 1 has a byte to send.
REQ-009 req1_data  in  DATA_W  requester 1 payload.
REQ-010 req1_ready  out  1  requester 1 byte accepted this cycle when req1_valid is also high.
REQ-011 tx  out  1  serial line, idle high.
REQ-012 busy  out  1  frame in progress.
REQ-013 gnt  out  1  index of the requester that owns the current or most recent frame.
REQ-014 baud_tick  out  1  one-cycle pulse on the last clk30M cycle of each bit period.

Function
REQ-015 State machine: IDLE, START, DATA, STOP; 8N1 framing (1 start bit low, DATA_W data bits LSB first, 1 stop bit high).
REQ-016 req0_ready and req1_ready are low outside IDLE; in IDLE, at most one of them is high, namely the arbitration winner.
REQ-017 Arbitration in IDLE is round-robin: if only one valid is high, that requester wins; if both are high, the requester other than the current gnt wins.
REQ-018 Accept = valid && ready of the winner: the payload is latched into the shift register, gnt is updated, and the state moves to START on the next edge.
REQ-019 The bit counter is 12 bits; it is cleared on accept, counts 0..CLK_DIV-1 in START/DATA/STOP, and wraps to 0 on the cycle after baud_tick.
REQ-020 baud_tick = (count == CLK_DIV-1) while not IDLE; baud_tick is never high in IDLE.
REQ-021 tx is registered: it goes low on the edge after accept, and each bit holds for exactly CLK_DIV cycles.
REQ-022 START→DATA on baud_tick; DATA shifts right on each baud_tick; DATA→STOP on the baud_tick of bit index DATA_W-1; STOP→IDLE on baud_tick.
REQ-023 A frame occupies exactly (DATA_W+2)*CLK_DIV cycles of tx; at least one IDLE cycle with tx high separates frames.
REQ-024 busy is high in START, DATA and STOP, and low in IDLE.
REQ-025 Input changes on reqN_data or reqN_valid after accept do not affect the frame in flight.
REQ-026 A valid deasserted before ready is not a violation; no byte is accepted in that case.

Reset
REQ-027 Asserting rst at any time, including mid-frame, immediately forces: state IDLE, tx=1, busy=0, gnt=1 (so requester 0 wins first contention), count=0, shift register=0, baud_tick=0.
REQ-028 A frame aborted by reset is discarded; it is not resumed.
REQ-029 While rst is high, req0_ready=0 and req1_ready=0.

Structure
REQ-030 The shared package holds the state enum, the default CLK_DIV constant (3125) and the counter width constant (12).
REQ-031 One sub-module, uart_baud_cnt: counter with clear, enable and tick output, instantiated once.

Verification (CLK_DIV=4, DATA_W=8 unless stated)
REQ-032 Single send: req0_valid with data 0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total; busy high for 40 cycles.
REQ-033 Contention: both valid from reset with data 0x11 and 0x22 → 0x11 is sent first (gnt=0), then 0x22 (gnt=1), with exactly one idle-high cycle between the frames.
REQ-034 Fairness: both valid held for 4 frames → grant order 0,1,0,1.
REQ-035 Mid-frame reset: rst pulsed at cycle 17 of a frame → tx=1 and busy=0 asynchronously; the next accepted byte is sent with a complete start bit.
REQ-036 Default divider: CLK_DIV=3125 → baud_tick period is exactly 3125 cycles (104.167 us at 30 MHz); no tick appears while IDLE.
REQ-037 Stability: req0_data changed to 0xFF one cycle after accept of 0x00 → the line still transmits 0x00.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg
//   Shared definitions for the scheduled UART transmitter:
//   - state_t          : transmitter frame state
//   - CLK_DIV_DEFAULT  : clk30M cycles per bit at 9600 baud (30 MHz / 9600)
//   - CNT_W            : width of the per-bit cycle counter
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int unsigned CLK_DIV_DEFAULT = 3125;
  localparam int unsigned CNT_W           = 12;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt
//   Per-bit cycle counter. Counts 0..CLK_DIV-1 while enabled and wraps to 0
//   after the terminal count. A clear has priority over counting.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-high reset (count -> 0)
//   clr   in  synchronous clear
//   en    in  count enable; tick is suppressed while low
//   tick  out high on the last cycle of each bit period
module uart_baud_cnt
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Two-requester UART transmitter (8N1 style framing, DATA_W data bits,
//   LSB first) with round-robin arbitration between the requesters.
// Ports:
//   clk30M      in  system clock
//   rst         in  asynchronous active-high reset
//   req0_valid  in  requester 0 has a byte
//   req0_data   in  requester 0 payload
//   req0_ready  out requester 0 accepted when req0_valid also high
//   req1_valid  in  requester 1 has a byte
//   req1_data   in  requester 1 payload
//   req1_ready  out requester 1 accepted when req1_valid also high
//   tx          out serial line, idle high (registered)
//   busy        out frame in progress
//   gnt         out requester owning the current / most recent frame
//   baud_tick   out pulse on the last cycle of each bit period
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk30M,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              tx,
  output logic              busy,
  output logic              gnt,
  output logic              baud_tick
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  bit_idx;
  logic              accept;

  // Round-robin: on contention the requester that did not own the last
  // frame wins. Readies are only offered in IDLE and never during reset.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst && state == IDLE) begin
      if (req0_valid && (!req1_valid || gnt)) begin
        req0_ready = 1'b1;
      end else if (req1_valid) begin
        req1_ready = 1'b1;
      end
    end
  end

  assign accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  uart_baud_cnt #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_cnt (
    .clk  (clk30M),
    .rst  (rst),
    .clr  (accept),
    .en   (state != IDLE),
    .tick (baud_tick)
  );

  // tx is driven one bit ahead: each baud_tick loads the level for the
  // next bit period, so every bit is held for exactly CLK_DIV cycles.
  always_ff @(posedge clk30M or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      gnt     <= 1'b1;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= START;
            tx      <= 1'b0;
            busy    <= 1'b1;
            gnt     <= req1_ready;
            shreg   <= req1_ready ? req1_data : req0_data;
            bit_idx <= '0;
          end
        end
        START: begin
          if (baud_tick) begin
            state   <= DATA;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_idx == LAST_IDX) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (baud_tick) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
